// File: rtl/reg_file_mp_pkg.sv
// Shared constants, index type and write-port arbitration helper for the
// multi-port register file.
package reg_file_mp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_ADDR_W     = $clog2(DEF_NUM_REGS);
    localparam int ZERO_REG_IDX   = 0;
    localparam int MAX_WR_PORTS   = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic hit;
        logic port;
    } wr_sel_t;

    // ports[p] = write port p targets the register in question; the
    // highest-index hitting port wins.
    function automatic wr_sel_t resolve_wr(input logic [MAX_WR_PORTS-1:0] ports);
        wr_sel_t s;
        s = '0;
        for (int p = 0; p < MAX_WR_PORTS; p++) begin
            if (ports[p]) begin
                s.hit  = 1'b1;
                s.port = p[0];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/reserve bundle of the multi-port register file. No handshake:
// every input is sampled on each rising clk, read outputs are combinational.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_WR_PORTS-1:0]                 wr_en;
    logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]     wr_reg;
    logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;
    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_reg;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]                 rd_pending;
    logic                                    rsv_en;
    logic [ADDR_W-1:0]                       rsv_reg;
    logic                                    wr_conflict;

    modport master (
        output wr_en, wr_reg, wr_data, rd_reg, rsv_en, rsv_reg,
        input  rd_data, rd_pending, wr_conflict
    );

    modport slave (
        input  wr_en, wr_reg, wr_data, rd_reg, rsv_en, rsv_reg,
        output rd_data, rd_pending, wr_conflict
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register pending bits: set on reserve, cleared on writeback; a reserve
// on the same edge as a write to that register keeps the bit set.
module reg_file_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int NUM_WR_PORTS = 2,
    parameter int ZERO_REG     = 1,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_WR_PORTS-1:0]          wr_en,
    input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0] wr_reg,
    input  logic                             rsv_en,
    input  logic [ADDR_W-1:0]                rsv_reg,
    output logic [NUM_REGS-1:0]              pending
);

    logic [NUM_REGS-1:0] pending_nxt;

    always_comb begin
        pending_nxt = pending;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en[p]) begin
                pending_nxt[wr_reg[p]] = 1'b0;
            end
        end
        // Reserve is applied last: the newer producer supersedes the writeback.
        if (rsv_en) begin
            pending_nxt[rsv_reg] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp_sva.sv
// Property checker bound into reg_file_mp: read data known, register 0 never
// pending, and wr_conflict only after a same-index double write.
module reg_file_mp_sva #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int ZERO_REG     = 1,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input logic                                 clk,
    input logic                                 rst,
    input logic [NUM_WR_PORTS-1:0]              wr_en,
    input logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]  wr_reg,
    input logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]  rd_reg,
    input logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data,
    input logic [NUM_REGS-1:0]                  pending,
    input logic                                 wr_conflict
);

    logic dbl;

    generate
        if (NUM_WR_PORTS == 2) begin : g_dbl
            assign dbl = (&wr_en) && (wr_reg[0] == wr_reg[1]) &&
                         !((ZERO_REG != 0) && (wr_reg[0] == '0));
        end else begin : g_no_dbl
            assign dbl = 1'b0;
        end
    endgenerate

    a_rd_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(rd_reg) |-> !$isunknown(rd_data));

    a_conflict_cause: assert property (@(posedge clk) disable iff (rst)
        wr_conflict |-> $past(dbl));

    generate
        if (ZERO_REG != 0) begin : g_zero
            a_zero_not_pending: assert property (@(posedge clk) disable iff (rst)
                !pending[0]);
        end
    endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, write-port priority, optional bypass and
// hardwired zero, plus a pending scoreboard for hazard detection.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int BYPASS       = 1,
    parameter int ZERO_REG     = 1,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);

    logic [NUM_WR_PORTS-1:0]                 wr_en;
    logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]     wr_reg;
    logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;
    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_reg;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_REGS-1:0]                     pending;
    logic                                    wr_conflict_q;
    logic                                    dbl_write;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    wr_sel_t               wsel [NUM_REGS];

    assign wr_en   = bus.wr_en;
    assign wr_reg  = bus.wr_reg;
    assign wr_data = bus.wr_data;
    assign rd_reg  = bus.rd_reg;

    // Winning write port per register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [MAX_WR_PORTS-1:0] hit;
            hit = '0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                hit[p] = wr_en[p] && (wr_reg[p] == ADDR_W'(r));
            end
            wsel[r] = resolve_wr(hit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wsel[r].hit && !((ZERO_REG != 0) && (r == ZERO_REG_IDX))) begin
                    regs[r] <= wr_data[wsel[r].port];
                end
            end
        end
    end

    generate
        if (NUM_WR_PORTS == 2) begin : g_dbl
            assign dbl_write = (&wr_en) && (wr_reg[0] == wr_reg[1]) &&
                               !((ZERO_REG != 0) && (wr_reg[0] == ADDR_W'(ZERO_REG_IDX)));
        end else begin : g_no_dbl
            assign dbl_write = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= dbl_write;
        end
    end

    // Read muxes; rst forces zero so a bypassed write cannot leak out during reset.
    always_comb begin
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            logic [MAX_WR_PORTS-1:0] rhit;
            wr_sel_t                 rsel;
            rhit = '0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                rhit[p] = wr_en[p] && (wr_reg[p] == rd_reg[i]);
            end
            rsel = resolve_wr(rhit);
            if (rst || ((ZERO_REG != 0) && (rd_reg[i] == ADDR_W'(ZERO_REG_IDX)))) begin
                rd_data_c[i] = '0;
            end else if ((BYPASS != 0) && rsel.hit) begin
                rd_data_c[i] = wr_data[rsel.port];
            end else begin
                rd_data_c[i] = regs[rd_reg[i]];
            end
        end
    end

    reg_file_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .ZERO_REG     (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_reg  (wr_reg),
        .rsv_en  (bus.rsv_en),
        .rsv_reg (bus.rsv_reg),
        .pending (pending)
    );

    always_comb begin
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            bus.rd_pending[i] = pending[rd_reg[i]];
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing instance (a) and a non-bypassing one (b)
// share the same stimulus; expectations are queued and checked at negedge.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    // Selector codes: dut*8 + item.
    localparam int RD0 = 0, RD1 = 1, PD0 = 2, PD1 = 3, CONF = 4;
    localparam int DA = 0, DB = 8;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]         wr_en;
    logic [1:0][AW-1:0] wr_reg;
    logic [1:0][DW-1:0] wr_data;
    logic [1:0][AW-1:0] rd_reg;
    logic               rsv_en;
    logic [AW-1:0]      rsv_reg;

    logic [DW-1:0] exp_q[$];
    int            sel_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    reg_file_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) if_a ();
    reg_file_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) if_b ();

    assign if_a.wr_en = wr_en;     assign if_b.wr_en = wr_en;
    assign if_a.wr_reg = wr_reg;   assign if_b.wr_reg = wr_reg;
    assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
    assign if_a.rd_reg = rd_reg;   assign if_b.rd_reg = rd_reg;
    assign if_a.rsv_en = rsv_en;   assign if_b.rsv_en = rsv_en;
    assign if_a.rsv_reg = rsv_reg; assign if_b.rsv_reg = rsv_reg;

    reg_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2),
                  .BYPASS(1), .ZERO_REG(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    reg_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2),
                  .BYPASS(0), .ZERO_REG(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));

    bind reg_file_mp reg_file_mp_sva #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD_PORTS(NUM_RD_PORTS),
        .NUM_WR_PORTS(NUM_WR_PORTS), .ZERO_REG(ZERO_REG)
    ) u_sva (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .rd_reg(rd_reg),
        .rd_data(rd_data_c), .pending(pending), .wr_conflict(wr_conflict_q)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic drive_wr(input int p, input logic [AW-1:0] r, input logic [DW-1:0] d);
        wr_en[p]   = 1'b1;
        wr_reg[p]  = r;
        wr_data[p] = d;
    endtask

    task automatic drive_rsv(input logic [AW-1:0] r);
        rsv_en  = 1'b1;
        rsv_reg = r;
    endtask

    task automatic expect_val(input int sel, input logic [DW-1:0] e, input string name);
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(name);
    endtask

    task automatic expect_both(input int item, input logic [DW-1:0] e, input string name);
        expect_val(DA + item, e, {name, "_a"});
        expect_val(DB + item, e, {name, "_b"});
    endtask

    function automatic logic [DW-1:0] actual(input int sel);
        case (sel)
            DA + RD0:  return if_a.rd_data[0];
            DA + RD1:  return if_a.rd_data[1];
            DA + PD0:  return DW'(if_a.rd_pending[0]);
            DA + PD1:  return DW'(if_a.rd_pending[1]);
            DA + CONF: return DW'(if_a.wr_conflict);
            DB + RD0:  return if_b.rd_data[0];
            DB + RD1:  return if_b.rd_data[1];
            DB + PD0:  return DW'(if_b.rd_pending[0]);
            DB + PD1:  return DW'(if_b.rd_pending[1]);
            DB + CONF: return DW'(if_b.wr_conflict);
            default:   return 'x;
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic [DW-1:0] got;
        int            s;
        string         n;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            s   = sel_q.pop_front();
            n   = name_q.pop_front();
            got = actual(s);
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", n, got, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        wr_en = '0; wr_reg = '0; wr_data = '0;
        rd_reg = '0; rsv_en = 1'b0; rsv_reg = '0;
        rd_reg[0] = 5'd5;
        @(posedge clk);
        #1;

        // Held in reset
        expect_both(RD0, 32'h0, "rst_rd0");
        expect_both(PD0, 32'h0, "rst_pend0");
        expect_both(CONF, 32'h0, "rst_conf");
        next_cycle();

        // x5 <= DEADBEEF, reserve x6
        rst = 1'b0;
        rd_reg[0] = 5'd5; rd_reg[1] = 5'd6;
        drive_wr(0, 5'd5, 32'hDEAD_BEEF);
        drive_rsv(5'd6);
        expect_val(DA + RD0, 32'hDEAD_BEEF, "byp_x5_a");
        expect_val(DB + RD0, 32'h0, "nobyp_x5_b");
        expect_both(PD1, 32'h0, "pend_x6_before");
        next_cycle();

        expect_both(RD0, 32'hDEAD_BEEF, "x5_stored");
        expect_both(PD1, 32'h1, "pend_x6_set");
        next_cycle();

        // Asynchronous reset mid-cycle with a write in flight
        drive_wr(0, 5'd5, 32'h77);
        #2 rst = 1'b1;
        expect_both(RD0, 32'h0, "async_rst_rd0");
        expect_both(PD1, 32'h0, "async_rst_pend");
        expect_both(CONF, 32'h0, "async_rst_conf");
        next_cycle();

        rst = 1'b0;
        expect_both(RD0, 32'h0, "rst_write_dropped");
        next_cycle();

        // Dual write, different registers
        rd_reg[0] = 5'd3; rd_reg[1] = 5'd4;
        drive_wr(0, 5'd3, 32'h11);
        drive_wr(1, 5'd4, 32'h22);
        expect_val(DA + RD0, 32'h11, "dual_byp_x3");
        expect_val(DA + RD1, 32'h22, "dual_byp_x4");
        expect_val(DB + RD0, 32'h0, "dual_nobyp_x3");
        expect_val(DB + RD1, 32'h0, "dual_nobyp_x4");
        next_cycle();

        expect_both(RD0, 32'h11, "dual_x3");
        expect_both(RD1, 32'h22, "dual_x4");
        expect_both(CONF, 32'h0, "dual_no_conf");
        next_cycle();

        // Collision on x7: port 1 wins
        rd_reg[0] = 5'd7;
        drive_wr(0, 5'd7, 32'hAAAA);
        drive_wr(1, 5'd7, 32'h5555);
        expect_val(DA + RD0, 32'h5555, "coll_byp_x7");
        expect_val(DB + RD0, 32'h0, "coll_nobyp_x7");
        expect_both(CONF, 32'h0, "coll_conf_before");
        next_cycle();

        expect_both(RD0, 32'h5555, "coll_x7");
        expect_both(CONF, 32'h1, "coll_conf_pulse");
        next_cycle();

        expect_both(CONF, 32'h0, "coll_conf_drop");
        next_cycle();

        // Bypass on both read ports
        rd_reg[0] = 5'd9; rd_reg[1] = 5'd9;
        drive_wr(0, 5'd9, 32'h1234);
        expect_val(DA + RD0, 32'h1234, "byp_x9_rd0");
        expect_val(DA + RD1, 32'h1234, "byp_x9_rd1");
        expect_val(DB + RD0, 32'h0, "nobyp_x9_old");
        next_cycle();

        expect_val(DB + RD0, 32'h1234, "nobyp_x9_new");
        next_cycle();

        // Zero register: double write plus reserve
        rd_reg[0] = 5'd0;
        drive_wr(0, 5'd0, 32'hFFFF_FFFF);
        drive_wr(1, 5'd0, 32'hFFFF_FFFF);
        drive_rsv(5'd0);
        expect_both(RD0, 32'h0, "x0_byp_zero");
        next_cycle();

        expect_both(RD0, 32'h0, "x0_zero");
        expect_both(PD0, 32'h0, "x0_not_pending");
        expect_both(CONF, 32'h0, "x0_no_conf");
        next_cycle();

        // Scoreboard on x12
        rd_reg[0] = 5'd12;
        drive_rsv(5'd12);
        expect_both(PD0, 32'h0, "sb_x12_before");
        next_cycle();

        drive_rsv(5'd12);
        drive_wr(0, 5'd12, 32'h99);
        expect_both(PD0, 32'h1, "sb_x12_set");
        expect_val(DA + RD0, 32'h99, "sb_x12_byp");
        next_cycle();

        drive_wr(0, 5'd12, 32'hAB);
        expect_both(PD0, 32'h1, "sb_rsv_wins");
        expect_val(DA + RD0, 32'hAB, "sb_x12_byp2");
        expect_val(DB + RD0, 32'h99, "sb_x12_stored");
        next_cycle();

        rd_reg[1] = 5'd3;
        expect_both(PD0, 32'h0, "sb_x12_cleared");
        expect_both(RD0, 32'hAB, "sb_x12_final");
        expect_both(RD1, 32'h11, "x3_retained");
        next_cycle();

        // Clear via write port 1
        rd_reg[1] = 5'd13;
        drive_rsv(5'd13);
        expect_both(PD1, 32'h0, "sb_x13_before");
        next_cycle();

        drive_wr(1, 5'd13, 32'h13);
        expect_both(PD1, 32'h1, "sb_x13_set");
        expect_val(DA + RD1, 32'h13, "sb_x13_byp");
        next_cycle();

        expect_both(PD1, 32'h0, "sb_x13_cleared_p1");
        next_cycle();

        repeat (4) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read RV32I reg_file.
- Configurable width, depth, read ports and write ports.
- Optional write-to-read bypass and an optional hardwired-zero register 0.
- Per-register pending scoreboard: a future pipelined core reserves a destination register at issue, the reservation clears at writeback, and hazard logic reads the pending status.

Parameters:
- DATA_WIDTH, 32, bits per register.
- NUM_REGS, 32, number of registers; must be a power of 2 and at least 2.
- NUM_RD_PORTS, 2, number of read ports (1..4).
- NUM_WR_PORTS, 2, number of write ports (1..2).
- BYPASS, 1, 1 = a same-cycle write is visible on the read data; 0 = read returns the stored value.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending.
- ADDR_W (localparam), $clog2(NUM_REGS), register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  NUM_WR_PORTS  per-port write enable.
- wr_reg  in  NUM_WR_PORTS x ADDR_W  per-port write index.
- wr_data  in  NUM_WR_PORTS x DATA_WIDTH  per-port write data.
- rd_reg  in  NUM_RD_PORTS x ADDR_W  per-port read index.
- rd_data  out  NUM_RD_PORTS x DATA_WIDTH  per-port read data, combinational.
- rd_pending  out  NUM_RD_PORTS  the register addressed by rd_reg[i] is reserved, combinational.
- rsv_en  in  1  reserve a destination register this cycle.
- rsv_reg  in  ADDR_W  index of the register to reserve.
- wr_conflict  out  1  registered; pulses one cycle after two enabled writes hit the same register.

Behaviour:
- Reset (asynchronous, active-high): all registers clear to 0, all pending bits clear to 0, wr_conflict = 0.
  - Consequently rd_data = 0 and rd_pending = 0 while rst is high.
  - Reset asserted mid-operation discards any write on that edge.
- Write: on posedge clk, for each port p with wr_en[p] set, reg[wr_reg[p]] <= wr_data[p].
  - Two ports writing the same register in one cycle: the higher-index port wins.
  - wr_conflict <= 1 on that edge, else 0.
  - A collision on register 0 with ZERO_REG=1 does not set wr_conflict.
- Read: rd_data[i] = reg[rd_reg[i]], combinational, zero latency.
  - BYPASS=1: if any enabled write port targets rd_reg[i] in the same cycle, rd_data[i] returns that port's wr_data, using the highest-index matching port.
  - BYPASS=0: the new value appears the cycle after the edge.
  - ZERO_REG=1 and rd_reg[i]=0: rd_data[i] = 0 always, with or without bypass.
- Scoreboard: one pending bit per register, updated on posedge clk.
  - Set: rsv_en sets pending[rsv_reg].
  - Clear: any enabled write clears pending[wr_reg[p]].
  - Simultaneous reserve and write to the same register: the reserve wins and the bit stays set (a new producer supersedes the old).
  - Reserving an already pending register leaves it set; this is legal.
  - ZERO_REG=1: pending[0] is held at 0.
  - rd_pending[i] = pending[rd_reg[i]], taken from the registered state only; a same-cycle write does not clear it combinationally.
- Width rules:
  - Indices are exactly ADDR_W bits, so there are no out-of-range accesses.
  - Data is stored unmodified; there is no sign or zero extension.
- Assertions (bound module):
  - No X on rd_data when rd_reg is known.
  - pending[0] is never 1 when ZERO_REG=1.
  - wr_conflict is only set one cycle after a same-index double write.

Decomposition:
- Extend riscv_32i_defs_pkg, or add reg_file_mp_pkg, with:
  - default DATA_WIDTH and NUM_REGS constants;
  - ZERO_REG_IDX;
  - a typedef for the register index type;
  - a function resolve_wr(ports) returning the winning port per register.
- One sub-module: reg_file_scoreboard, which owns the pending bits and the set/clear priority.
- The storage array, write-port priority and bypass muxes stay in reg_file_mp.
- Reference model: reg_file_ref_model is extended with a pending array, multi-port update, and a bypass-aware read.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst mid-cycle (asynchronous) -> rd_data of x5 = 0 immediately; rd_pending = 0; wr_conflict = 0.
- Dual write, different registers: port0 x3=0x11, port1 x4=0x22 -> next cycle x3 = 0x11, x4 = 0x22; wr_conflict = 0.
- Dual write collision: both ports target x7, port0 = 0xAAAA, port1 = 0x5555 -> x7 = 0x5555; wr_conflict = 1 for exactly one cycle.
- Bypass: BYPASS=1, write x9 = 0x1234 while rd_reg[0] = 9 -> rd_data[0] = 0x1234 in the same cycle. With BYPASS=0 -> old value this cycle, 0x1234 on the next.
- Zero register: write x0 = 0xFFFFFFFF and rsv x0 -> rd_data = 0, rd_pending = 0, no conflict flagged even on a double write.
- Scoreboard:
  - rsv x12 -> rd_pending = 1 next cycle;
  - rsv x12 together with a port0 write to x12 -> still pending;
  - a lone write to x12 -> pending = 0 the following cycle.
